// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and a
// constant-width helper usable in parameter defaults.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_prio_enc.sv
// Priority encoder, highest set bit wins; valid flags any bit set.
// Purely combinational.
module prio_enc
    import rr_arbiter_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] out,
    output logic         valid
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        out   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                out   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot registered grant held until done, owner drop or
// hold timeout; one-cycle grant latency and a dead cycle between grants.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N        = 8,
    parameter int W        = clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_id,
    output logic         grant_valid,
    output logic         timeout
);

    localparam int HW = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = '1;

    state_t         state, state_nxt;
    logic [W-1:0]   last_id, last_id_nxt;
    logic [HW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [N-1:0]   grant_nxt;
    logic [W-1:0]   grant_id_nxt;
    logic           grant_valid_nxt;
    logic           timeout_nxt;

    logic [N-1:0]   mask;
    logic [W-1:0]   masked_id, full_id, win_id;
    logic           masked_vld, any_req;
    logic           hold_hit;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (W'(i) < last_id);
        end
    end

    prio_enc #(.N(N), .W(W)) u_enc_masked (
        .in    (req & mask),
        .out   (masked_id),
        .valid (masked_vld)
    );

    prio_enc #(.N(N), .W(W)) u_enc_full (
        .in    (req),
        .out   (full_id),
        .valid (any_req)
    );

    // Requests below the previous winner go first; otherwise wrap to the top.
    assign win_id   = masked_vld ? masked_id : full_id;
    assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt       = state;
        last_id_nxt     = last_id;
        hold_cnt_nxt    = hold_cnt;
        grant_nxt       = grant;
        grant_id_nxt    = grant_id;
        grant_valid_nxt = grant_valid;
        timeout_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt       = BUSY;
                    grant_nxt       = N'(1) << win_id;
                    grant_id_nxt    = win_id;
                    last_id_nxt     = win_id;
                    grant_valid_nxt = 1'b1;
                    hold_cnt_nxt    = '0;
                end
            end
            BUSY: begin
                if (done || !req[grant_id] || hold_hit) begin
                    state_nxt       = IDLE;
                    grant_nxt       = '0;
                    grant_valid_nxt = 1'b0;
                    timeout_nxt     = hold_hit;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_id     <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_id     <= last_id_nxt;
            hold_cnt    <= hold_cnt_nxt;
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            grant_valid <= grant_valid_nxt;
            timeout     <= timeout_nxt;
        end
    end

endmodule
